// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types, default width and length clamp for the bit stream serializer
package ser_pkg;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } ser_state_t;

    localparam int SER_WIDTH = 22;

    // Lengths above the word width send the whole word
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/bit_stream_serializer_if.sv
// rtl/bit_stream_serializer_if.sv - parallel word handshake into the bit stream serializer
interface bit_stream_serializer_if
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
);

    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_len,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_len,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/ser_hold_buf.sv
// rtl/ser_hold_buf.sv - one-entry holding register for the next word while the shifter is busy
module ser_hold_buf
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic [LEN_W-1:0] len
);

    // Clear wins; a load in the same cycle as a drain refills the entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
            len  <= '0;
        end else if (clear) begin
            full <= 1'b0;
            data <= '0;
            len  <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
            len  <= load_len;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel word to 1-bit serial stream; SER_LSB_FIRST_EN selects LSB-first
module bit_stream_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH    = SER_WIDTH,
    parameter int   LEN_W    = $clog2(WIDTH + 1),
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    bit_stream_serializer_if.slave        bus,
    input  logic                          abort,
    output logic                          x_out,
    output logic                          x_valid,
    output logic                          busy
);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [LEN_W-1:0] hold_len;
    logic             hold_load;
    logic             hold_drain;

    logic [LEN_W-1:0] in_len_c;
    logic             accept;
    logic             take_word;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;
    logic             cur_bit;

`ifdef SER_LSB_FIRST_EN
    assign shifted = shreg_q >> 1;
    assign cur_bit = shreg_q[0];
`else
    assign shifted = shreg_q << 1;
    assign cur_bit = shreg_q[WIDTH-1];
`endif

    assign in_len_c     = LEN_W'(clamp_len(32'(bus.in_len), WIDTH));
    assign bus.in_ready = rdy_en_q & ~hold_full;
    // An offered word during abort is dropped, not accepted
    assign accept       = bus.in_valid & bus.in_ready & ~abort;
    // Zero-length words complete the handshake but are never stored
    assign take_word    = accept && (in_len_c != '0);
    assign last_bit     = (state_q == S_SHIFT) && (cnt_q == LEN_W'(1));

    assign x_valid = (state_q == S_SHIFT);
    assign x_out   = (state_q == S_SHIFT) ? cur_bit : IDLE_VAL;
    assign busy    = (state_q == S_SHIFT) | hold_full;

    // Holds in_ready low through reset and for the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // FSM, shifter and bit counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load, shift, or chain the next word on the last bit without a gap
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (take_word) begin
                        shreg_d = bus.in_data;
                        cnt_d   = in_len_c;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (last_bit) begin
                        if (hold_full) begin
                            shreg_d    = hold_data;
                            cnt_d      = hold_len;
                            hold_drain = 1'b1;
                            hold_load  = take_word;
                        end else if (take_word) begin
                            shreg_d = bus.in_data;
                            cnt_d   = in_len_c;
                        end else begin
                            state_d = S_IDLE;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        shreg_d   = shifted;
                        cnt_d     = cnt_q - LEN_W'(1);
                        hold_load = take_word;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    ser_hold_buf #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort),
        .load      (hold_load),
        .drain     (hold_drain),
        .load_data (bus.in_data),
        .load_len  (in_len_c),
        .full      (hold_full),
        .data      (hold_data),
        .len       (hold_len)
    );

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - directed self-checking bench for bit_stream_serializer
module tb_bit_stream_serializer;

    localparam logic [21:0] P22 = 22'b0111001010100100010010;

    logic clk;
    logic reset;
    logic abort;
    logic x_out;
    logic x_valid;
    logic busy;
    int   cyc;
    int   n_checks;
    int   n_pass;

    logic bits[$];
    int   cycs[$];

    bit_stream_serializer_if bus ();

    bit_stream_serializer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .abort   (abort),
        .x_out   (x_out),
        .x_valid (x_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (x_valid) begin
            bits.push_back(x_out);
            cycs.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Places the emitted sequence so it leaves the serializer in written order
    function automatic logic [21:0] mk(input logic [21:0] seq, input int len);
        logic [21:0] r;
        r = '0;
        for (int i = 0; i < len; i++) begin
`ifdef SER_LSB_FIRST_EN
            r[i] = seq[len-1-i];
`else
            r[21-i] = seq[len-1-i];
`endif
        end
        return r;
    endfunction

    function automatic logic [31:0] packq();
        logic [31:0] v;
        v = '0;
        foreach (bits[i]) v = {v[30:0], bits[i]};
        return v;
    endfunction

    function automatic logic gapless();
        logic ok;
        ok = 1'b1;
        foreach (cycs[i]) if (cycs[i] != cycs[0] + i) ok = 1'b0;
        return ok;
    endfunction

    task automatic clr();
        bits.delete();
        cycs.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic offer(input logic [21:0] d, input logic [4:0] l, output int acc);
        int guard;
        guard = 0;
        bus.in_data  = d;
        bus.in_len   = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("offer_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int a, a1, a2, a3, a0;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = '0;
        repeat (3) @(negedge clk);
        check("rst_x_out", {31'b0, x_out}, 32'd0);
        check("rst_x_valid", {31'b0, x_valid}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        #1 check("rel_ready_low", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("rel_ready_high", {31'b0, bus.in_ready}, 32'd1);

        // 22-bit bench pattern
        clr();
        offer(mk(P22, 22), 5'd22, a);
        bus.in_valid = 1'b0;
        wait_idle();
        check("t1_count", bits.size(), 32'd22);
        check("t1_bits", packq(), {10'b0, P22});
        check("t1_latency", cycs[0], a);
        check("t1_gapless", {31'b0, gapless()}, 32'd1);
        check("t1_idle_xval", {31'b0, x_valid}, 32'd0);
        check("t1_idle_xout", {31'b0, x_out}, 32'd0);

        // Back-to-back words through the holding buffer
        clr();
        offer(mk(22'b1011, 4), 5'd4, a1);
        offer(mk(22'b010, 3), 5'd3, a2);
        check("t2_hold_accept", a2, a1 + 1);
        check("t2_ready_full", {31'b0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t2_ready_still_low", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("t2_ready_rise", {31'b0, bus.in_ready}, 32'd1);
        wait_idle();
        check("t2_count", bits.size(), 32'd7);
        check("t2_bits", packq(), 32'b1011010);
        check("t2_gapless", {31'b0, gapless()}, 32'd1);
        check("t2_latency", cycs[0], a1);

        // Zero-length word between two len-2 words
        clr();
        offer(mk(22'b11, 2), 5'd2, a1);
        offer(22'h3FFFFF, 5'd0, a0);
        offer(mk(22'b00, 2), 5'd2, a3);
        bus.in_valid = 1'b0;
        check("t3_len0_accept", a0, a1 + 1);
        wait_idle();
        check("t3_count", bits.size(), 32'd4);
        check("t3_bits", packq(), 32'b1100);
        check("t3_gapless", {31'b0, gapless()}, 32'd1);

        // Abort on the third bit with a held word pending
        clr();
        offer(mk(22'b10110011, 8), 5'd8, a);
        offer(mk(22'b1111, 4), 5'd4, a1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t4_third_bit", {31'b0, x_out}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_xvalid", {31'b0, x_valid}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (12) @(negedge clk);
        check("t4_count", bits.size(), 32'd3);
        check("t4_bits", packq(), 32'b101);

        // Length above WIDTH clamps to WIDTH
        clr();
        offer(mk(P22, 22), 5'd31, a);
        bus.in_valid = 1'b0;
        wait_idle();
        check("t5_count", bits.size(), 32'd22);
        check("t5_bits", packq(), {10'b0, P22});

        // Asynchronous reset mid-word
        clr();
        offer(mk(22'hFF, 8), 5'd8, a);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t6_pre_xout", {31'b0, x_out}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_xout", {31'b0, x_out}, 32'd0);
        check("t6_xvalid", {31'b0, x_valid}, 32'd0);
        check("t6_ready", {31'b0, bus.in_ready}, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clr();
        offer(mk(22'b101, 3), 5'd3, a);
        bus.in_valid = 1'b0;
        wait_idle();
        check("t6_count", bits.size(), 32'd3);
        check("t6_bits", packq(), 32'b101);
        check("t6_latency", cycs[0], a);

`ifdef SER_LSB_FIRST_EN
        // Raw LSB-aligned word
        clr();
        offer(22'b0011, 5'd4, a);
        bus.in_valid = 1'b0;
        wait_idle();
        check("t7_count", bits.size(), 32'd4);
        check("t7_bits", packq(), 32'b1100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Upstream feeder for the sequence detectors: accepts parallel words over a valid/ready handshake and emits them as a 1-bit-per-clock serial stream on x_out, which drives the detector's x input.
- MSB-first by default; a one-entry holding buffer lets back-to-back words stream with no idle gap.
- Carries a per-word bit length so partial words and exact bench patterns, e.g. the 22-bit 0111001010100100010010, can be replayed in hardware.

Parameters:
- WIDTH, 22, maximum word width in bits (>=2)
- LEN_W, $clog2(WIDTH+1), width of the length field
- IDLE_VAL, 1'b0, value driven on x_out when no bit is being sent

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  parallel word; valid bits are MSB-aligned, in_data[WIDTH-1 -: in_len]
- in_len  input  LEN_W  number of bits to send, 0..WIDTH
- in_valid  input  1  word offered
- in_ready  output  1  block can accept a word this cycle
- abort  input  1  synchronous flush of current and held words
- x_out  output  1  serial bit to the detector's x
- x_valid  output  1  x_out carries a data bit this cycle
- busy  output  1  shifter or holding buffer occupied

Behaviour:
- Reset (reset=0, asynchronous): shifter, holding buffer and bit counter cleared; state IDLE. Outputs: x_out=IDLE_VAL, x_valid=0, in_ready=0 while reset is low, busy=0. in_ready becomes 1 on the first clock after release.
- Handshake: a word transfers on a rising edge with in_valid & in_ready. in_ready = !hold_full, so it is registered-state only. Holding in_valid without ready is legal; data must stay stable until accepted.
- States:
  - IDLE: shifter empty.
  - SHIFT: emitting bits.
- IDLE + accept with len>0: at the same edge the word loads directly into the shifter, bit_cnt=len and the state goes to SHIFT. The first bit appears on x_out with x_valid=1 in the cycle after the accept edge (1-cycle latency).
- SHIFT: one bit per clock.
  - x_out is the registered shifter MSB.
  - bit_cnt decrements on each edge.
  - On the edge retiring the last bit:
    - hold_full: load the held word, no gap.
    - hold empty with simultaneous accept: load the incoming word directly, no gap.
    - otherwise: go to IDLE, x_out=IDLE_VAL, x_valid=0.
- Accept during SHIFT goes to the holding buffer. If the holding buffer drains at the same edge, the new word enters the holding buffer.
- len=0: the word is accepted and discarded; no bits, no cycle lost.
- len>WIDTH: clamped to WIDTH.
- abort=1 at an edge: shifter and buffer cleared, state IDLE, x_valid=0 next cycle. Any word offered that cycle is also dropped. in_ready is unaffected.
- busy = (state==SHIFT) | hold_full.
- Reset asserted mid-word truncates immediately. No partial bit is ever re-emitted after reset release.

Optional Feature:
- Macro SER_LSB_FIRST_EN.
- Defined: valid bits are LSB-aligned, in_data[in_len-1:0], sent bit 0 first; the shifter shifts right.
- Undefined: MSB-aligned, MSB-first as above.
- Latency, handshake and gapless behaviour are identical in both builds.

Decomposition:
- Package ser_pkg:
  - state enum {S_IDLE, S_SHIFT}
  - default WIDTH constant
  - len-clamp function
- Sub-module ser_hold_buf: one-entry data+len register with full flag, load/drain strobes and a clear input for abort. The top holds the FSM, shifter and counter.

Test Plan:
- Load in_data=22'b0111001010100100010010, in_len=22 after reset release.
  - x_out sequence 0,1,1,1,0,0,1,0,1,0,1,0,0,1,0,0,0,1,0,0,1,0 starts one cycle after accept.
  - x_valid is high for exactly 22 cycles, then x_out=0 and x_valid=0.
  - With the detector chained, its y matches the standalone run.
- Back-to-back words 4'b1011 (len 4) then 3'b010 (len 3, MSB-aligned), in_valid held high.
  - x_out = 1,0,1,1,0,1,0 with no gap.
  - in_ready drops once the holding buffer fills and rises as the second word loads.
- A word with in_len=0 between two len-2 words (11, 00).
  - Output 1,1,0,0 contiguous; the empty word produces no gap.
- abort asserted on the 3rd bit of a len-8 word with a held word pending.
  - x_valid=0 the next cycle, busy=0, held word never emitted.
- reset driven low mid-word.
  - x_out=0, x_valid=0, in_ready=0 immediately (asynchronous, no clock edge).
  - After release, a new len-3 word 101 emits cleanly.
- SER_LSB_FIRST_EN build: in_data low bits 4'b0011, len 4.
  - x_out = 1,1,0,0.
